// File: rtl/display_scheduler_pkg.sv
// Shared board constants and FSM encodings for the 7-segment display scheduler.
package display_scheduler_pkg;

  localparam logic [6:0] SEVSEG_OFF = 7'b1111111;
  localparam int NUM_DIGITS = 8;
  localparam int NIBBLE_W   = 4;
  localparam int WORD_W     = NUM_DIGITS * NIBBLE_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_BLANK = 2'd2
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/display_scheduler_rr_next_valid.sv
// Round-robin search for the next valid source, starting at start_i (inclusive)
// or just after it (exclusive, start_i itself checked last).
module rr_next_valid #(
  parameter int N_SRC = 4,
  parameter int IDX_W = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] valid_i,
  input  logic [IDX_W-1:0] start_i,
  input  logic             incl_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             found_o
);

  logic [IDX_W:0]   pos;
  logic [IDX_W-1:0] sel;

  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    pos     = '0;
    sel     = '0;
    for (int k = 0; k < N_SRC; k++) begin
      pos = {1'b0, start_i} + (IDX_W+1)'(k) + {{IDX_W{1'b0}}, ~incl_i};
      if (pos >= (IDX_W+1)'(N_SRC)) pos = pos - (IDX_W+1)'(N_SRC);
      sel = pos[IDX_W-1:0];
      if (!found_o && valid_i[sel]) begin
        found_o = 1'b1;
        idx_o   = sel;
      end
    end
  end

endmodule

// File: rtl/display_scheduler.sv
// Rotates the eight-digit display between valid sources with a programmable
// dwell time and a blanking gap on every switch.
module display_scheduler
  import display_scheduler_pkg::*;
#(
  parameter int N_SRC        = 4,
  parameter int DWELL_CYCLES = 50_000_000,
  parameter int BLANK_CYCLES = 2_500_000,
  parameter int IDX_W        = $clog2(N_SRC)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_SRC-1:0]        src_valid,
  input  logic [N_SRC*WORD_W-1:0] src_numbers,
  input  logic                    next_pressed,
  input  logic                    hold,
  output logic [WORD_W-1:0]       numbers_out,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic [IDX_W-1:0]        cur_src,
  output logic                    switched
);

  localparam int CNT_W = max_int(1, $clog2(max_int(DWELL_CYCLES, BLANK_CYCLES)));
  localparam logic [CNT_W-1:0] DWELL_LD = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LD = CNT_W'(BLANK_CYCLES - 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      cur_src_q, cur_src_d;
  logic [WORD_W-1:0]     numbers_q, numbers_d;
  logic [NUM_DIGITS-1:0] digit_en_q, digit_en_d;
  logic                  switched_q, switched_d;

  logic [WORD_W-1:0] words [N_SRC];
  logic [IDX_W-1:0]  found_idx;
  logic              found;

  for (genvar i = 0; i < N_SRC; i++) begin : g_words
    assign words[i] = src_numbers[WORD_W*i +: WORD_W];
  end

  // IDLE searches inclusively from cur_src; BLANK searches strictly after it.
  rr_next_valid #(.N_SRC(N_SRC), .IDX_W(IDX_W)) u_rr (
    .valid_i (src_valid),
    .start_i (cur_src_q),
    .incl_i  (state_q == ST_IDLE),
    .idx_o   (found_idx),
    .found_o (found)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      cur_src_q  <= '0;
      numbers_q  <= '0;
      digit_en_q <= '0;
      switched_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cur_src_q  <= cur_src_d;
      numbers_q  <= numbers_d;
      digit_en_q <= digit_en_d;
      switched_q <= switched_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cur_src_d  = cur_src_q;
    numbers_d  = numbers_q;
    digit_en_d = '0;
    switched_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (found) begin
          state_d    = ST_SHOW;
          cnt_d      = DWELL_LD;
          cur_src_d  = found_idx;
          numbers_d  = words[found_idx];
          digit_en_d = '1;
          switched_d = 1'b1;
        end
      end
      ST_SHOW: begin
        numbers_d = words[cur_src_q];
        if (next_pressed || !src_valid[cur_src_q] || (cnt_q == '0 && !hold)) begin
          state_d = ST_BLANK;
          cnt_d   = BLANK_LD;
        end else begin
          digit_en_d = '1;
          if (!hold) cnt_d = cnt_q - 1'b1;
        end
      end
      ST_BLANK: begin
        if (cnt_q == '0) begin
          if (found) begin
            state_d    = ST_SHOW;
            cnt_d      = DWELL_LD;
            cur_src_d  = found_idx;
            numbers_d  = words[found_idx];
            digit_en_d = '1;
            switched_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign numbers_out = numbers_q;
  assign digit_en    = digit_en_q;
  assign cur_src     = cur_src_q;
  assign switched    = switched_q;

endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench for display_scheduler with short dwell/blank times.
module tb_display_scheduler;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   src_valid;
  logic [127:0] src_numbers;
  logic         next_pressed;
  logic         hold;
  logic [31:0]  numbers_out;
  logic [7:0]   digit_en;
  logic [1:0]   cur_src;
  logic         switched;

  int tests = 0;
  int fails = 0;

  display_scheduler #(.N_SRC(4), .DWELL_CYCLES(8), .BLANK_CYCLES(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .src_valid    (src_valid),
    .src_numbers  (src_numbers),
    .next_pressed (next_pressed),
    .hold         (hold),
    .numbers_out  (numbers_out),
    .digit_en     (digit_en),
    .cur_src      (cur_src),
    .switched     (switched)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pulse next_pressed from SHOW, then expect the given source after the 2-cycle gap.
  task automatic skip_to(input logic [1:0] exp_src, input logic [31:0] exp_num);
    next_pressed = 1'b1;
    cyc();
    chk("skip_blank_en", {24'd0, digit_en}, 32'h00);
    next_pressed = 1'b0;
    cyc();
    chk("skip_blank2_en", {24'd0, digit_en}, 32'h00);
    cyc();
    chk("skip_src", {30'd0, cur_src}, {30'd0, exp_src});
    chk("skip_num", numbers_out, exp_num);
    chk("skip_sw", {31'd0, switched}, 32'd1);
  endtask

  initial begin
    rst          = 1'b1;
    src_valid    = 4'b0000;
    next_pressed = 1'b0;
    hold         = 1'b0;
    src_numbers  = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0000};

    // 1: reset values, first SHOW, full dwell, gap, round-robin to source 2
    #12;
    chk("rst_num", numbers_out, 32'h0);
    chk("rst_en", {24'd0, digit_en}, 32'h0);
    chk("rst_src", {30'd0, cur_src}, 32'd0);
    chk("rst_sw", {31'd0, switched}, 32'd0);
    src_valid = 4'b0101;
    cyc();
    rst = 1'b0;
    chk("idle_en", {24'd0, digit_en}, 32'h0);
    cyc();
    chk("t1_src", {30'd0, cur_src}, 32'd0);
    chk("t1_num", numbers_out, 32'h0);
    chk("t1_en", {24'd0, digit_en}, 32'hFF);
    chk("t1_sw", {31'd0, switched}, 32'd1);
    for (int i = 0; i < 7; i++) begin
      cyc();
      chk("t1_dwell_en", {24'd0, digit_en}, 32'hFF);
      chk("t1_dwell_sw", {31'd0, switched}, 32'd0);
    end
    cyc();
    chk("t1_blank1", {24'd0, digit_en}, 32'h0);
    chk("t1_blank_num", numbers_out, 32'h0);
    cyc();
    chk("t1_blank2", {24'd0, digit_en}, 32'h0);
    cyc();
    chk("t1_src2", {30'd0, cur_src}, 32'd2);
    chk("t1_num2", numbers_out, 32'h2222_2222);
    chk("t1_sw2", {31'd0, switched}, 32'd1);

    // 2: walk to source 1, hold for 20 cycles, live data update, skip while held
    src_valid = 4'b1111;
    skip_to(2'd3, 32'h3333_3333);
    skip_to(2'd0, 32'h0000_0000);
    skip_to(2'd1, 32'h1111_1111);
    hold = 1'b1;
    src_numbers[63:32] = 32'hABCD_0123;
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk("t2_hold_src", {30'd0, cur_src}, 32'd1);
      chk("t2_hold_en", {24'd0, digit_en}, 32'hFF);
    end
    chk("t2_live_num", numbers_out, 32'hABCD_0123);
    src_numbers[63:32] = 32'h1111_1111;
    next_pressed = 1'b1;
    cyc();
    chk("t2_next_blank", {24'd0, digit_en}, 32'h0);
    next_pressed = 1'b0;
    cyc();
    chk("t2_blank2", {24'd0, digit_en}, 32'h0);
    cyc();
    chk("t2_src2", {30'd0, cur_src}, 32'd2);
    hold = 1'b0;

    // 3: lone source 3 reshown with a fresh switched pulse, then drops out
    src_valid = 4'b1000;
    cyc();
    chk("t3_drop2_blank", {24'd0, digit_en}, 32'h0);
    cyc();
    cyc();
    chk("t3_src3", {30'd0, cur_src}, 32'd3);
    chk("t3_sw_a", {31'd0, switched}, 32'd1);
    cyc();
    chk("t3_sw_low", {31'd0, switched}, 32'd0);
    for (int i = 0; i < 6; i++) cyc();
    chk("t3_last_show", {24'd0, digit_en}, 32'hFF);
    cyc();
    chk("t3_blank", {24'd0, digit_en}, 32'h0);
    cyc();
    cyc();
    chk("t3_reshow_src", {30'd0, cur_src}, 32'd3);
    chk("t3_reshow_sw", {31'd0, switched}, 32'd1);
    chk("t3_reshow_num", numbers_out, 32'h3333_3333);
    cyc();
    cyc();
    src_valid = 4'b0000;
    cyc();
    chk("t3_drop_blank", {24'd0, digit_en}, 32'h0);
    cyc();
    cyc();
    chk("t3_idle_en", {24'd0, digit_en}, 32'h0);
    chk("t3_idle_src", {30'd0, cur_src}, 32'd3);
    cyc();
    chk("t3_idle_stay", {24'd0, digit_en}, 32'h0);

    // 4: next_pressed on dwell expiry gives one gap and one advance
    src_valid = 4'b0001;
    cyc();
    chk("t4_src0", {30'd0, cur_src}, 32'd0);
    src_valid = 4'b1111;
    for (int i = 0; i < 7; i++) cyc();
    chk("t4_pre_exp_en", {24'd0, digit_en}, 32'hFF);
    next_pressed = 1'b1;
    cyc();
    chk("t4_blank1", {24'd0, digit_en}, 32'h0);
    chk("t4_blank_src", {30'd0, cur_src}, 32'd0);
    cyc();
    chk("t4_blank2", {24'd0, digit_en}, 32'h0);
    next_pressed = 1'b0;
    cyc();
    chk("t4_src1", {30'd0, cur_src}, 32'd1);
    chk("t4_en", {24'd0, digit_en}, 32'hFF);
    chk("t4_num1", numbers_out, 32'h1111_1111);

    // 5: asynchronous reset in the middle of a BLANK cycle
    next_pressed = 1'b1;
    cyc();
    next_pressed = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    chk("t5_rst_en", {24'd0, digit_en}, 32'h0);
    chk("t5_rst_num", numbers_out, 32'h0);
    chk("t5_rst_src", {30'd0, cur_src}, 32'd0);
    src_valid = 4'b0010;
    #2;
    rst = 1'b0;
    cyc();
    chk("t5_src1", {30'd0, cur_src}, 32'd1);
    chk("t5_num1", numbers_out, 32'h1111_1111);
    chk("t5_sw", {31'd0, switched}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
